mul_seq_ctrl: RTL

- Sequential shift-add multiplier controller that time-shares the datapath's single 16-bit ripple adder (module Add) to form a 32-bit unsigned product over 16 iterations.
- Sits beside the EX stage. The pipeline holds the instruction while Busy is high and captures Product on Done.
- Owns its FSM, iteration counter, accumulator and multiplier shift register. The adder is purely combinational inside it.

---
 rtl/mul_seq_ctrl_pkg.sv | 20 ++
 rtl/mul_seq_ctrl_add.sv | 15 +
 rtl/mul_seq_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared constants, state encoding and operand gating helper for the
// sequential shift-add multiplier controller.
package mul_seq_ctrl_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Partial product for one iteration: the multiplicand or nothing.
    function automatic logic [WIDTH-1:0] gate_operand(input logic sel,
                                                      input logic [WIDTH-1:0] op);
        return sel ? op : {WIDTH{1'b0}};
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_add.sv
// 16-bit adder shared with the datapath; purely combinational, carry-out
// is the 17th bit of the sum.
module mul_seq_ctrl_add
    import mul_seq_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier controller: 16 iterations over one shared
// 16-bit adder produce an exact 32-bit unsigned product.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic                 Flush,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    state_t               state_r, state_nxt_s;
    logic [WIDTH-1:0]     mcand_r, mcand_nxt_s;
    logic [WIDTH-1:0]     hi_r, hi_nxt_s;
    logic [WIDTH-1:0]     lo_r, lo_nxt_s;
    logic [CNT_W-1:0]     count_r, count_nxt_s;
    logic [2*WIDTH-1:0]   product_r, product_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;

    logic [WIDTH-1:0]     add_b_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 cout_s;

    assign add_b_s = gate_operand(lo_r[0], mcand_r);

    mul_seq_ctrl_add u_add (
        .a    (hi_r),
        .b    (add_b_s),
        .cin  (1'b0),
        .s    (sum_s),
        .cout (cout_s)
    );

    // Next-state, operand capture and shift/accumulate decode.
    always_comb begin
        state_nxt_s   = state_r;
        mcand_nxt_s   = mcand_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        count_nxt_s   = count_r;
        product_nxt_s = product_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start && !Flush) begin
                    mcand_nxt_s = Multiplicand;
                    hi_nxt_s    = {WIDTH{1'b0}};
                    lo_nxt_s    = Multiplier;
                    count_nxt_s = {CNT_W{1'b0}};
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Flush) begin
                    count_nxt_s = {CNT_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end else begin
                    // 33-bit right shift of {Cout, S, Lo} drops the consumed multiplier bit.
                    hi_nxt_s    = {cout_s, sum_s[WIDTH-1:1]};
                    lo_nxt_s    = {sum_s[0], lo_r[WIDTH-1:1]};
                    count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_r == CNT_W'(WIDTH-1)) begin
                        product_nxt_s = {cout_s, sum_s, lo_r[WIDTH-1:1]};
                        state_nxt_s   = ST_DONE;
                    end else begin
                        state_nxt_s   = ST_RUN;
                    end
                end
            end
            default: begin
                count_nxt_s = {CNT_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_RUN);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State, datapath and output flops.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r   <= ST_IDLE;
            mcand_r   <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            mcand_r   <= mcand_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            count_r   <= count_nxt_s;
            product_r <= product_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Product = product_r;

endmodule
